// File: rtl/switch_capture.sv
// Debounced player-switch capture with a valid/ready handshake toward the game logic.
// Optional feature: define SWITCH_CAPTURE_ONEHOT_EN to reject multi-switch patterns.
`timescale 1ns/1ps
module switch_capture #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switch,
  input  logic             enable,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] pattern,
  output logic             reject,
  output logic [7:0]       presses
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    ARMED        = 2'd2,
    PRESENT      = 2'd3
  } state_t;

  logic [WIDTH-1:0] sync1_r, sync2_r, cand_r, deb_r;
  logic [CW-1:0]    cnt_r;
  state_t           state_r, state_s;
  logic             valid_r, reject_r;
  logic [WIDTH-1:0] pattern_r;
  logic [7:0]       presses_r;
  logic             load_s, reject_s, xfer_s;

`ifdef SWITCH_CAPTURE_ONEHOT_EN
  function automatic logic multi_hot(input logic [WIDTH-1:0] v);
    return |(v & (v - WIDTH'(1)));
  endfunction
`endif

  // Synchronizer and stability counter; cand_r is the previous synchronized sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      cand_r  <= {WIDTH{1'b0}};
      deb_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= switch;
      sync2_r <= sync1_r;
      cand_r  <= sync2_r;
      if (sync2_r != cand_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        deb_r <= cand_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Next-state and per-cycle event decode; enable low overrides everything except a completed transfer.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    reject_s = 1'b0;
    xfer_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) state_s = WAIT_RELEASE;
        else        state_s = IDLE;
      end
      WAIT_RELEASE: begin
        if (deb_r == {WIDTH{1'b0}}) state_s = ARMED;
        else                        state_s = WAIT_RELEASE;
      end
      ARMED: begin
        if (deb_r != {WIDTH{1'b0}}) begin
`ifdef SWITCH_CAPTURE_ONEHOT_EN
          if (multi_hot(deb_r)) begin
            reject_s = 1'b1;
            state_s  = WAIT_RELEASE;
          end else begin
            load_s  = 1'b1;
            state_s = PRESENT;
          end
`else
          load_s  = 1'b1;
          state_s = PRESENT;
`endif
        end else begin
          state_s = ARMED;
        end
      end
      PRESENT: begin
        if (ready) begin
          xfer_s  = 1'b1;
          state_s = WAIT_RELEASE;
        end else begin
          state_s = PRESENT;
        end
      end
      default: state_s = IDLE;
    endcase
    if (!enable) begin
      state_s  = IDLE;
      load_s   = 1'b0;
      reject_s = 1'b0;
    end else begin
      state_s  = state_s;
    end
  end

  // State and registered outputs; pattern is frozen while presenting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      valid_r   <= 1'b0;
      reject_r  <= 1'b0;
      pattern_r <= {WIDTH{1'b0}};
      presses_r <= 8'd0;
    end else begin
      state_r  <= state_s;
      valid_r  <= (state_s == PRESENT);
      reject_r <= reject_s;
      if (load_s)                  pattern_r <= deb_r;
      else if (state_s == PRESENT) pattern_r <= pattern_r;
      else                         pattern_r <= {WIDTH{1'b0}};
      if (xfer_s) presses_r <= presses_r + 8'd1;
      else        presses_r <= presses_r;
    end
  end

  assign valid   = valid_r;
  assign pattern = pattern_r;
  assign presses = presses_r;
`ifdef SWITCH_CAPTURE_ONEHOT_EN
  assign reject  = reject_r;
`else
  assign reject  = 1'b0;
`endif

endmodule

// File: tb/tb_switch_capture.sv
// Directed testbench for switch_capture with hand-computed expectations.
`timescale 1ns/1ps
module tb_switch_capture;
  localparam int WIDTH = 10;
  localparam int DEB   = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] switch = '0;
  logic             enable = 1'b0;
  logic             ready = 1'b0;
  logic             valid, reject;
  logic [WIDTH-1:0] pattern;
  logic [7:0]       presses;

  int checks = 0;
  int errors = 0;
  int exp_presses = 0;

  always #5 clock = ~clock;

  switch_capture #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset_n(reset_n), .switch(switch), .enable(enable),
    .ready(ready), .valid(valid), .pattern(pattern), .reject(reject),
    .presses(presses)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_valid(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      step(1);
      n++;
      if (valid) ok = 1'b1;
    end
  endtask

  task automatic handshake();
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    exp_presses++;
  endtask

  task automatic release_sw();
    switch = '0;
    step(25);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int timeouts;
    bit ok;
    bit seen;

    step(2);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_pattern", pattern, 0);
    check_eq("rst_reject", reject, 0);
    check_eq("rst_presses", presses, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    step(20);
    check_eq("idle_valid", valid, 0);

    // Single press: first sampling edge is n=1, valid expected DEB+4 edges on.
    switch = 10'b0000100000;
    wait_valid(60, n, ok);
    check_eq("press_ok", ok, 1);
    check_eq("press_latency", n, DEB + 4);
    check_eq("press_pattern", pattern, 10'h020);

    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i % 5 == 0) switch = (i % 10 == 0) ? 10'h300 : 10'h020;
      step(1);
      if (pattern !== 10'h020 || valid !== 1'b1) seen = 1'b1;
    end
    check_eq("hold_stable", seen, 0);

    switch = 10'h020;
    handshake();
    check_eq("xfer_valid", valid, 0);
    check_eq("xfer_presses", presses, 1);

    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (valid) seen = 1'b1;
    end
    check_eq("no_repeat", seen, 0);

    release_sw();
    switch = 10'h001;
    wait_valid(60, n, ok);
    check_eq("repress_ok", ok, 1);
    check_eq("repress_pattern", pattern, 10'h001);
    handshake();
    check_eq("repress_presses", presses, 2);

    // Bouncing input every 5 cycles must never settle.
    release_sw();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) switch = ((i / 5) % 2 == 0) ? 10'h004 : 10'h000;
      step(1);
      if (valid) seen = 1'b1;
    end
    check_eq("bounce_no_valid", seen, 0);
    switch = 10'h004;
    wait_valid(60, n, ok);
    check_eq("bounce_final_ok", ok, 1);
    check_eq("bounce_pattern", pattern, 10'h004);
    handshake();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (valid) seen = 1'b1;
    end
    check_eq("bounce_once", seen, 0);
    check_eq("bounce_presses", presses, 3);

    release_sw();
    switch = 10'h003;
`ifdef SWITCH_CAPTURE_ONEHOT_EN
    seen = 1'b0;
    n = 0;
    while (n < 60 && reject !== 1'b1) begin
      step(1);
      n++;
      if (valid) seen = 1'b1;
    end
    check_eq("reject_pulse", reject, 1);
    check_eq("reject_valid", valid, 0);
    step(1);
    check_eq("reject_width", reject, 0);
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (valid) seen = 1'b1;
    end
    check_eq("reject_novalid", seen, 0);
`else
    wait_valid(60, n, ok);
    check_eq("multi_ok", ok, 1);
    check_eq("multi_pattern", pattern, 10'h003);
    check_eq("multi_reject", reject, 0);
    handshake();
    check_eq("multi_presses", presses, exp_presses);
`endif

    release_sw();
    timeouts = 0;
    while (exp_presses < 256) begin
      switch = 10'h010;
      wait_valid(60, n, ok);
      if (!ok) begin
        timeouts++;
        break;
      end
      handshake();
      switch = '0;
      step(25);
    end
    check_eq("wrap_timeouts", timeouts, 0);
    check_eq("wrap_presses", presses, exp_presses % 256);

    switch = 10'h010;
    wait_valid(60, n, ok);
    check_eq("dis_ok", ok, 1);
    enable = 1'b0;
    step(1);
    check_eq("dis_valid", valid, 0);
    check_eq("dis_pattern", pattern, 0);
    check_eq("dis_presses", presses, exp_presses % 256);

    enable = 1'b1;
    release_sw();
    switch = 10'h040;
    wait_valid(60, n, ok);
    check_eq("disx_ok", ok, 1);
    enable = 1'b0;
    ready  = 1'b1;
    step(1);
    ready  = 1'b0;
    exp_presses++;
    check_eq("disx_valid", valid, 0);
    check_eq("disx_presses", presses, exp_presses % 256);
    enable = 1'b1;

    // Asynchronous reset in the middle of a debounce, then in the middle of PRESENT.
    release_sw();
    switch = 10'h080;
    step(5);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rstdeb_valid", valid, 0);
    check_eq("rstdeb_pattern", pattern, 0);
    check_eq("rstdeb_presses", presses, 0);
    check_eq("rstdeb_reject", reject, 0);
    step(2);
    reset_n = 1'b1;
    exp_presses = 0;
    wait_valid(60, n, ok);
    check_eq("rstdeb_restart_ok", ok, 1);
    check_eq("rstdeb_restart_pat", pattern, 10'h080);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rstpres_valid", valid, 0);
    check_eq("rstpres_pattern", pattern, 0);
    check_eq("rstpres_presses", presses, 0);
    step(1);
    reset_n = 1'b1;
    step(2);
    check_eq("restart_valid", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
